// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// State encoding doubles as the grant pair: bit 0 = gnt0, bit 1 = gnt1.
package mux_pkg;

    localparam int W_DEFAULT = 2;
    localparam int HOLD_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester, grant and downstream handshake bundle for mux2_rr_arbiter.
// The arbiter takes the slave view; requesters and the consumer take the master view.
interface mux2_rr_arbiter_if #(
    parameter int W = mux_pkg::W_DEFAULT
);

    logic         req0;
    logic [W-1:0] d0;
    logic         req1;
    logic [W-1:0] d1;
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  req0, d0, req1, d1, out_ready,
        output gnt0, gnt1, sel, out, out_valid
    );

    modport master (
        output req0, d0, req1, d1, out_ready,
        input  gnt0, gnt1, sel, out, out_valid
    );

endinterface

// File: rtl/mux2_rr_arbiter_mux.sv
// Gate-level 2:1 word mux: y = s ? d1 : d0, built bit by bit from primitives.
module mux2_rr_arbiter_mux #(
    parameter int W = 2
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         s,
    output logic [W-1:0] y
);

    logic         s_n;
    logic [W-1:0] t0;
    logic [W-1:0] t1;

    not u_inv (s_n, s);

    for (genvar i = 0; i < W; i++) begin : g_bit
        and u_and0 (t0[i], d0[i], s_n);
        and u_and1 (t1[i], d1[i], s);
        or  u_or   (y[i], t0[i], t1[i]);
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with burst hold driving a 2:1 mux into a one-deep
// output register consumed through a valid/ready handshake.
module mux2_rr_arbiter
    import mux_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux2_rr_arbiter_if.slave    bus
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_t              state, state_n;
    logic                last_owner, last_owner_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [W-1:0]        mux_y;
    logic [W-1:0]        out_p1;
    logic                vld_p1;
    logic                can_load;
    logic                own_req;
    logic                oth_req;
    logic                accept;
    logic                release_own;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] c);
        if (c >= MAX_HOLD_C)
            return MAX_HOLD_C;
        return c + 4'd1;
    endfunction

    // A saturated counter still ends the burst once the other side shows up.
    function automatic logic hold_done(input logic [HOLD_W-1:0] c);
        return ({1'b0, c} + 5'd1) >= {1'b0, MAX_HOLD_C};
    endfunction

    mux2_rr_arbiter_mux #(.W(W)) u_mux (
        .d0 (bus.d0),
        .d1 (bus.d1),
        .s  (state[1]),
        .y  (mux_y)
    );

    assign can_load    = !vld_p1 || bus.out_ready;
    assign own_req     = (state == ST_OWN0) ? bus.req0 : bus.req1;
    assign oth_req     = (state == ST_OWN0) ? bus.req1 : bus.req0;
    assign accept      = (state != ST_IDLE) && own_req && can_load;
    assign release_own = !own_req || (accept && hold_done(hold_cnt) && oth_req);

    always_comb begin
        state_n      = state;
        last_owner_n = last_owner;
        hold_cnt_n   = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (bus.req0 && bus.req1)
                    state_n = last_owner ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)
                    state_n = ST_OWN0;
                else if (bus.req1)
                    state_n = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (release_own) begin
                    if (oth_req)
                        state_n = (state == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                    else
                        state_n = ST_IDLE;
                    last_owner_n = (state == ST_OWN1);
                    hold_cnt_n   = '0;
                end else if (accept) begin
                    hold_cnt_n = sat_inc(hold_cnt);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            last_owner <= last_owner_n;
            hold_cnt   <= hold_cnt_n;
        end
    end

    // Output register stage: selected word lands here on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (accept) begin
            out_p1 <= mux_y;
            vld_p1 <= 1'b1;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.gnt0      = state[0];
    assign bus.gnt1      = state[1];
    assign bus.sel       = state[1];
    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (W=2, MAX_HOLD=4); status packs {gnt0,gnt1,sel,out_valid,out}.
module tb_mux2_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux2_rr_arbiter_if #(.W(2)) bus ();

    mux2_rr_arbiter #(.W(2), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] status();
        return {bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [1:0] v0,
                         input logic r1, input logic [1:0] v1, input logic rdy);
        bus.req0      = r0;
        bus.d0        = v0;
        bus.req1      = r1;
        bus.d1        = v1;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0 = 1'($urandom_range(0, 1));
            bus.req1 = 1'($urandom_range(0, 1));
            bus.d0   = 2'($urandom_range(0, 3));
            bus.d1   = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (status() !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected 000000", i, status());
            end
        end
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        rst_n = 1'b1;
        step();
        checks++;
        if (status() !== 6'b100000) begin
            errors++;
            $display("FAIL reset_first_tie: got %b expected 100000", status());
        end
    endtask

    task automatic test_single();
        logic [1:0] seq [6];
        seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        do_reset();
        drive(1'b1, seq[0], 1'b0, 2'b00, 1'b1);
        step();
        checks++;
        if (status() !== 6'b100000) begin
            errors++;
            $display("FAIL single_grant: got %b expected 100000", status());
        end
        for (int i = 0; i < 6; i++) begin
            bus.d0 = seq[i];
            step();
            checks++;
            if (status() !== {4'b1001, seq[i]}) begin
                errors++;
                $display("FAIL single_word[%0d]: got %b expected %b", i, status(), {4'b1001, seq[i]});
            end
        end
    endtask

    task automatic test_contention();
        logic       exp_sel;
        logic [1:0] exp_out;
        do_reset();
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        step();
        checks++;
        if (status() !== 6'b100000) begin
            errors++;
            $display("FAIL contention_grant: got %b expected 100000", status());
        end
        for (int k = 0; k < 12; k++) begin
            step();
            exp_sel = 1'(((k + 1) / 4) % 2);
            exp_out = (((k / 4) % 2) != 0) ? 2'b10 : 2'b01;
            checks++;
            if (status() !== {~exp_sel, exp_sel, exp_sel, 1'b1, exp_out}) begin
                errors++;
                $display("FAIL contention[%0d]: got %b expected %b", k, status(),
                         {~exp_sel, exp_sel, exp_sel, 1'b1, exp_out});
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b1);
        step();
        step();
        checks++;
        if (status() !== 6'b011101) begin
            errors++;
            $display("FAIL bp_first_word: got %b expected 011101", status());
        end
        drive(1'b1, 2'b11, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (status() !== 6'b011101) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got %b expected 011101", i, status());
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (status() !== 6'b011110) begin
            errors++;
            $display("FAIL bp_resume: got %b expected 011110", status());
        end
        bus.d1 = 2'b11;
        step();
        checks++;
        if (status() !== 6'b011111) begin
            errors++;
            $display("FAIL bp_third_word: got %b expected 011111", status());
        end
        bus.d1 = 2'b00;
        step();
        checks++;
        if (status() !== 6'b100100) begin
            errors++;
            $display("FAIL bp_handover: got %b expected 100100", status());
        end
        step();
        checks++;
        if (status() !== 6'b100111) begin
            errors++;
            $display("FAIL bp_other_word: got %b expected 100111", status());
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        step();
        step();
        step();
        checks++;
        if (status() !== 6'b100101) begin
            errors++;
            $display("FAIL drop_two_words: got %b expected 100101", status());
        end
        bus.req0 = 1'b0;
        step();
        checks++;
        if (status() !== 6'b011001) begin
            errors++;
            $display("FAIL drop_handover: got %b expected 011001", status());
        end
        step();
        checks++;
        if (status() !== 6'b011110) begin
            errors++;
            $display("FAIL drop_other_word: got %b expected 011110", status());
        end
        bus.req1 = 1'b0;
        step();
        checks++;
        if (status() !== 6'b000010) begin
            errors++;
            $display("FAIL drop_idle: got %b expected 000010", status());
        end
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        checks++;
        if (status() !== 6'b100010) begin
            errors++;
            $display("FAIL drop_tie_to_0: got %b expected 100010", status());
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        checks++;
        if (status() !== 6'b011010) begin
            errors++;
            $display("FAIL drop_tie_to_1: got %b expected 011010", status());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
        step();
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (status() !== 6'b011111) begin
            errors++;
            $display("FAIL midrst_loaded: got %b expected 011111", status());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (status() !== 6'b000000) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 000000", status());
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_drop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
